// File: rtl/wb_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : wb_stage (with package core_pkg)
// Description : Write-back stage. Accepts one retiring instruction per
//               handshake, selects the write-back source, waits for the
//               data-memory response on loads, extracts and extends the
//               loaded value, and emits one registered register-file write.
//               Optional retire counter enabled by macro WB_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

package core_pkg;
   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;
endpackage

module wb_stage
   import core_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int REG_MEM_ADDR_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [DATA_WIDTH-1:0]         alu_result_i,
   input  logic [DATA_WIDTH-1:0]         pc_plus4_i,
   input  logic [REG_MEM_ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [2:0]                    funct3_i,
   input  logic                          RegWrite_i,
   input  wb_sel_e                       WBSel_i,
   input  logic                          dmem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]         dmem_rdata_i,
   output logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0]         wr_data_o,
   output logic                          wr_en_o,
   output logic                          err_o,
   output logic [63:0]                   instret_o
);

   typedef enum logic [0:0] {
      S_IDLE      = 1'b0,
      S_WAIT_LOAD = 1'b1
   } state_e;

   state_e                        state_q,    state_d;
   logic [REG_MEM_ADDR_WIDTH-1:0] rd_q,       rd_d;
   logic [2:0]                    funct3_q,   funct3_d;
   logic                          regwr_q,    regwr_d;
   logic [1:0]                    addr_lo_q,  addr_lo_d;
   logic                          wr_en_q,    wr_en_d;
   logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_WIDTH-1:0]         wr_data_q,  wr_data_d;
   logic                          err_q,      err_d;
   logic [7:0]                    load_byte;
   logic [15:0]                   load_half;
   logic [DATA_WIDTH-1:0]         load_val;

   assign in_ready_o = (state_q == S_IDLE);
   assign wr_en_o    = wr_en_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign err_o      = err_q;

   // Load extraction: pick byte/half by captured address bits, then extend
   always_comb begin
      load_byte = 8'h00;
      case (addr_lo_q)
         2'd0:    load_byte = dmem_rdata_i[7:0];
         2'd1:    load_byte = dmem_rdata_i[15:8];
         2'd2:    load_byte = dmem_rdata_i[23:16];
         default: load_byte = dmem_rdata_i[31:24];
      endcase
      // a[0] is ignored for halves; misalignment is resolved upstream
      load_half = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  load_val = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         3'b001:  load_val = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
         3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, load_half};
         default: load_val = dmem_rdata_i;   // LW and unused encodings
      endcase
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      funct3_d  = funct3_q;
      regwr_d   = regwr_q;
      addr_lo_d = addr_lo_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            // A response with no outstanding load is an error and writes nothing
            if (dmem_rvalid_i) begin
               err_d = 1'b1;
            end
            if (in_valid_i) begin
               rd_d      = rd_addr_i;
               funct3_d  = funct3_i;
               regwr_d   = RegWrite_i;
               addr_lo_d = alu_result_i[1:0];
               if (WBSel_i == WB_MEM) begin
                  state_d = S_WAIT_LOAD;
               end else begin
                  wr_en_d   = RegWrite_i && (rd_addr_i != '0);
                  wr_addr_d = rd_addr_i;
                  wr_data_d = (WBSel_i == WB_PC4) ? pc_plus4_i : alu_result_i;
               end
            end
         end
         S_WAIT_LOAD: begin
            if (dmem_rvalid_i) begin
               wr_en_d   = regwr_q && (rd_q != '0);
               wr_addr_d = rd_q;
               wr_data_d = load_val;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rd_q      <= '0;
         funct3_q  <= '0;
         regwr_q   <= 1'b0;
         addr_lo_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         funct3_q  <= funct3_d;
         regwr_q   <= regwr_d;
         addr_lo_q <= addr_lo_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic        retire;
   logic [63:0] instret_q, instret_d;

   // Count every completed instruction, independent of RegWrite or rd
   always_comb begin
      retire    = ((state_q == S_IDLE) && in_valid_i && (WBSel_i != WB_MEM)) ||
                  ((state_q == S_WAIT_LOAD) && dmem_rvalid_i);
      instret_d = instret_q + {63'd0, retire};
   end

   // Retire counter register; wraps naturally at 2^64
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret_o = instret_q;
`else
   assign instret_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_wb_stage;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] alu_result_i;
   logic [31:0] pc_plus4_i;
   logic [4:0]  rd_addr_i;
   logic [2:0]  funct3_i;
   logic        RegWrite_i;
   wb_sel_e     WBSel_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [4:0]  wr_addr_o;
   logic [31:0] wr_data_o;
   logic        wr_en_o;
   logic        err_o;
   logic [63:0] instret_o;

   int checks = 0;
   int errors = 0;

   wb_stage #(.DATA_WIDTH(32), .REG_MEM_ADDR_WIDTH(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .alu_result_i (alu_result_i),
      .pc_plus4_i   (pc_plus4_i),
      .rd_addr_i    (rd_addr_i),
      .funct3_i     (funct3_i),
      .RegWrite_i   (RegWrite_i),
      .WBSel_i      (WBSel_i),
      .dmem_rvalid_i(dmem_rvalid_i),
      .dmem_rdata_i (dmem_rdata_i),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .wr_en_o      (wr_en_o),
      .err_o        (err_o),
      .instret_o    (instret_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single accept edge
   task automatic issue(input wb_sel_e sel, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [2:0] f3, input logic rw);
      in_valid_i   = 1'b1;
      WBSel_i      = sel;
      rd_addr_i    = rd;
      alu_result_i = alu;
      pc_plus4_i   = pc4;
      funct3_i     = f3;
      RegWrite_i   = rw;
      tick();
      in_valid_i   = 1'b0;
   endtask

   // Full load: accept, idle wait cycles, then a one-cycle response
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] rdata,
                          input logic exp_en, input logic [31:0] exp_data);
      issue(WB_MEM, rd, addr, 32'h0, f3, 1'b1);
      check({tag, "_en_wait"}, {63'd0, wr_en_o}, 64'd0);
      tick();
      tick();
      check({tag, "_ready_wait"}, {63'd0, in_ready_o}, 64'd0);
      dmem_rdata_i  = rdata;
      dmem_rvalid_i = 1'b1;
      tick();
      dmem_rvalid_i = 1'b0;
      check({tag, "_en"}, {63'd0, wr_en_o}, {63'd0, exp_en});
      if (exp_en) begin
         check({tag, "_addr"}, {59'd0, wr_addr_o}, {59'd0, rd});
         check({tag, "_data"}, {32'd0, wr_data_o}, {32'd0, exp_data});
      end
      check({tag, "_ready"}, {63'd0, in_ready_o}, 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid_i = 1'b0; alu_result_i = '0; pc_plus4_i = '0; rd_addr_i = '0;
      funct3_i = '0; RegWrite_i = 1'b0; WBSel_i = WB_ALU;
      dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      tick();
      tick();
      check("rst_en",      {63'd0, wr_en_o},    64'd0);
      check("rst_addr",    {59'd0, wr_addr_o},  64'd0);
      check("rst_data",    {32'd0, wr_data_o},  64'd0);
      check("rst_err",     {63'd0, err_o},      64'd0);
      check("rst_instret", instret_o,           64'd0);
      check("rst_ready",   {63'd0, in_ready_o}, 64'd1);
      rst = 1'b0;

      // Back-to-back ALU writes
      issue(WB_ALU, 5'd3, 32'h11, 32'h0, 3'd0, 1'b1);
      check("b2b0_en",    {63'd0, wr_en_o},    64'd1);
      check("b2b0_addr",  {59'd0, wr_addr_o},  64'd3);
      check("b2b0_data",  {32'd0, wr_data_o},  64'h11);
      check("b2b0_ready", {63'd0, in_ready_o}, 64'd1);
      in_valid_i = 1'b1;
      issue(WB_ALU, 5'd4, 32'h22, 32'h0, 3'd0, 1'b1);
      check("b2b1_en",    {63'd0, wr_en_o},    64'd1);
      check("b2b1_addr",  {59'd0, wr_addr_o},  64'd4);
      check("b2b1_data",  {32'd0, wr_data_o},  64'h22);
      tick();
      check("idle_en",    {63'd0, wr_en_o},    64'd0);
      check("idle_hold",  {32'd0, wr_data_o},  64'h22);

      // JAL link and x0 suppression
      issue(WB_PC4, 5'd1, 32'hDEAD, 32'h104, 3'd0, 1'b1);
      check("jal_en",   {63'd0, wr_en_o},   64'd1);
      check("jal_addr", {59'd0, wr_addr_o}, 64'd1);
      check("jal_data", {32'd0, wr_data_o}, 64'h104);
      issue(WB_PC4, 5'd0, 32'hDEAD, 32'h104, 3'd0, 1'b1);
      check("jal_x0_en", {63'd0, wr_en_o}, 64'd0);
      // RegWrite low also suppresses the write
      issue(WB_ALU, 5'd9, 32'h99, 32'h0, 3'd0, 1'b0);
      check("norw_en", {63'd0, wr_en_o}, 64'd0);

      // Load extraction
      do_load("lb",  5'd5, 32'h0000_1002, 3'd0, 32'h1280_3456, 1'b1, 32'hFFFF_FF80);
      do_load("lbu", 5'd6, 32'h0000_1002, 3'd4, 32'h1280_3456, 1'b1, 32'h0000_0080);
      do_load("lb3", 5'd10, 32'h0000_1003, 3'd0, 32'h7F80_3456, 1'b1, 32'h0000_007F);
      do_load("lh",  5'd7, 32'h0000_2002, 3'd1, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001);
      do_load("lhu", 5'd11, 32'h0000_2002, 3'd5, 32'h8001_7FFF, 1'b1, 32'h0000_8001);
      do_load("lh0", 5'd12, 32'h0000_2001, 3'd1, 32'h8001_7FFF, 1'b1, 32'h0000_7FFF);
      do_load("lw",  5'd8, 32'h0000_3003, 3'd2, 32'h8001_7FFF, 1'b1, 32'h8001_7FFF);
      do_load("lx0", 5'd0, 32'h0000_3000, 3'd2, 32'h1234_5678, 1'b0, 32'h0);
      check("err_clean", {63'd0, err_o}, 64'd0);

      // Reset in the middle of a load abandons it
      issue(WB_MEM, 5'd13, 32'h0000_4000, 32'h0, 3'd2, 1'b1);
      check("mid_ready", {63'd0, in_ready_o}, 64'd0);
      rst = 1'b1;
      #1;
      check("arst_ready", {63'd0, in_ready_o}, 64'd1);
      check("arst_data",  {32'd0, wr_data_o},  64'd0);
      tick();
      rst = 1'b0;
      dmem_rdata_i  = 32'hCAFE_F00D;
      dmem_rvalid_i = 1'b1;
      tick();
      dmem_rvalid_i = 1'b0;
      check("stray_en",    {63'd0, wr_en_o},    64'd0);
      check("stray_err",   {63'd0, err_o},      64'd1);
      check("stray_ready", {63'd0, in_ready_o}, 64'd1);
      check("mid_instret", instret_o,           64'd0);

      // Retire count: three ALU completions plus one load to x0
      issue(WB_ALU, 5'd2, 32'h1, 32'h0, 3'd0, 1'b1);
      issue(WB_ALU, 5'd0, 32'h2, 32'h0, 3'd0, 1'b1);
      issue(WB_ALU, 5'd3, 32'h3, 32'h0, 3'd0, 1'b0);
      do_load("cnt_ld", 5'd0, 32'h0, 3'd2, 32'h5, 1'b0, 32'h0);
      tick();
`ifdef WB_RETIRE_CNT_EN
      check("instret", instret_o, 64'd4);
`else
      check("instret", instret_o, 64'd0);
`endif
      check("err_sticky", {63'd0, err_o}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage. Drives the register-file write port (`wr_addr`, `wr_data`, `wr_en`) that the decode stage consumes.
- Accepts one retiring instruction per handshake from the memory stage.
- Selects the write-back source and, for loads, waits for the data-memory response. It then aligns and sign/zero-extends the loaded value.
- Emits a single registered write pulse per instruction.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_MEM_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid_i  input  1  memory stage presents a retiring instruction.
- in_ready_o  output  1  stage can accept; high only in IDLE.
- alu_result_i  input  DATA_WIDTH  ALU result, or the load address for loads.
- pc_plus4_i  input  DATA_WIDTH  PC+4 for JAL/JALR link.
- rd_addr_i  input  REG_MEM_ADDR_WIDTH  destination register.
- funct3_i  input  3  load size/sign (`LB`=0, `LH`=1, `LW`=2, `LBU`=4, `LHU`=5).
- RegWrite_i  input  1  instruction writes rd.
- WBSel_i  input  wb_sel_e  write-back source; core_pkg members `WB_ALU`, `WB_MEM`, `WB_PC4`.
- dmem_rvalid_i  input  1  load data valid; single-cycle pulse.
- dmem_rdata_i  input  DATA_WIDTH  raw aligned 32-bit word from data memory.
- wr_addr_o  output  REG_MEM_ADDR_WIDTH  register-file write address.
- wr_data_o  output  DATA_WIDTH  register-file write data.
- wr_en_o  output  1  register-file write enable; one-cycle pulse.
- err_o  output  1  sticky: `dmem_rvalid_i` seen while not in WAIT_LOAD.
- instret_o  output  64  retired-instruction count (see Optional Feature).

Behaviour:
- Reset:
  - state = IDLE.
  - `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `err_o`=0, `instret_o`=0.
  - Captured fields cleared.
  - Reset mid-load abandons the load; a later `dmem_rvalid_i` in IDLE sets `err_o`.
- Combinational: `in_ready_o` = (state==IDLE). All other outputs are registered.
- Accept = `in_valid_i` && `in_ready_o`, sampled at the clock edge. The stage captures rd, funct3, RegWrite, WBSel, `alu_result_i[1:0]`, and the selected non-memory data.
- State IDLE, accept with WBSel != `WB_MEM`:
  - On the next edge, outputs show: `wr_en_o` = RegWrite && (rd != 0); `wr_addr_o` = rd.
  - `wr_data_o` = `alu_result_i` (`WB_ALU`) or `pc_plus4_i` (`WB_PC4`).
  - State stays IDLE, so back-to-back accepts give one write per cycle.
  - Latency: 1 cycle from accept to `wr_en_o`.
- State IDLE, accept with `WB_MEM`:
  - Go to WAIT_LOAD; `in_ready_o` drops the following cycle.
  - `wr_en_o`=0.
- State WAIT_LOAD:
  - On `dmem_rvalid_i`=1, register the extracted load value into `wr_data_o`.
  - `wr_en_o` = RegWrite && (rd != 0); `wr_addr_o` = rd; go to IDLE.
  - Latency: 1 cycle after rvalid.
  - A response in the same cycle as entering WAIT_LOAD is not possible: accept and rvalid are sampled on different edges.
- Load extraction, with a = captured addr[1:0]:
  - `LB`/`LBU`: byte `rdata[8a+7:8a]`, sign-/zero-extended.
  - `LH`/`LHU`: half `rdata[16*a[1]+15:16*a[1]]`, sign-/zero-extended; a[0] ignored (misalignment is handled upstream).
  - `LW`: full word, a ignored.
  - funct3 3, 6, 7: treated as `LW`.
- x0: a write to rd=0 never asserts `wr_en_o`. A load to x0 still waits for its response.
- `wr_en_o` is deasserted in every cycle that does not complete an instruction. `wr_addr_o` and `wr_data_o` hold their last values.
- `err_o`: set by `dmem_rvalid_i` in IDLE. Cleared only by reset. A stray response produces no write.

Optional Feature:
- Macro `WB_RETIRE_CNT_EN`.
- Defined: a 64-bit `instret_o` counter increments by 1 in the same cycle `wr_en_o` would be evaluated for a completed instruction (both non-load and load completions), regardless of RegWrite or rd. It wraps from 2^64-1 to 0.
- Undefined: counter logic absent; `instret_o` tied to 0.

Test Plan:
- Reset mid-WAIT_LOAD: accept `WB_MEM`, assert rst, deassert, then pulse `dmem_rvalid_i` -> no `wr_en_o`, `err_o`=1, `in_ready_o`=1.
- Back-to-back ALU ops: `WB_ALU`, rd=3, alu=0x11 then rd=4, alu=0x22 on consecutive cycles -> `wr_en_o` pulses on two consecutive cycles with (3,0x11), (4,0x22); `in_ready_o` stays 1.
- JAL link plus x0 suppression:
  - `WB_PC4`, rd=1, pc_plus4=0x104 -> write (1,0x104).
  - Same with rd=0 -> `wr_en_o` stays 0.
- LB sign-extension: addr=0x...2, rdata=0x12_80_34_56, funct3=0, rd=5, rvalid three cycles later -> `in_ready_o`=0 while waiting, then write (5,0xFFFFFF80); LBU -> 0x00000080.
- LH/LW alignment: LH addr[1:0]=2, rdata=0x8001_7FFF -> 0xFFFF8001. LW with addr[1:0]=3 -> full 0x80017FFF.
- With `WB_RETIRE_CNT_EN`: retire 3 ALU ops and 1 load to x0 -> `instret_o`=4. Without the macro -> `instret_o`=0 throughout.
